// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; it never needs to reach WIDTH, only WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtract cells: a half subtractor and a full subtractor made from two of them.
// Latency: purely combinational.
// Backpressure: none; the outputs follow the inputs.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic bout1;
    logic bout2;

    // First stage forms a-b, second stage removes the incoming borrow.
    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (bout1)
    );

    half_subtractor u_hs1 (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (bout2)
    );

    assign bout = bout1 | bout2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first, one bit per clock.
// Latency: done pulses WIDTH cycles after the accepted start; one op per WIDTH+2 cycles.
// Backpressure: start is only taken while ready=1; starts in RUN or DONE are dropped.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;

    assign last_bit = (cnt == CNT_LAST);

    // The single subtract cell: current operand LSBs plus the stored borrow.
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bor),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; ready/done decode straight from the state flops.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial ripple and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bor  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    bor    <= bout_bit;
                    if (last_bit) begin
                        // diff/borrow_out only move here, so they hold through IDLE.
                        diff       <= {d_bit, res_sr[WIDTH-1:1]};
                        borrow_out <= bout_bit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random operands.
// Latency: checks done lands exactly WIDTH cycles after the accepted start.
// Backpressure: checks that starts outside IDLE are dropped and back-to-back spacing.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         done;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic modulo 2^W.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        return W'((x - y) & ((1 << W) - 1));
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (int'(x) < int'(y));
    endfunction

    // Advance edge by edge until done is seen; cyc = edges after the start edge, -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
        int cyc;
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        start = 1'b1;
        a     = aa;
        b     = bb;
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        check({tag, "_ready_run"}, 32'(ready), 32'd0);
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(W));
        check({tag, "_diff"}, 32'(diff), 32'(ref_diff(aa, bb)));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(ref_borrow(aa, bb)));
        @(posedge clk); #1;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int ndone;
        int first_ready;
        logic [W-1:0] diff_at_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases.
        run_op(8'h05, 8'h03, "d05_03");
        run_op(8'h03, 8'h05, "d03_05");
        run_op(8'h80, 8'hFF, "d80_ff");
        run_op(8'hFF, 8'h01, "dff_01");
        run_op(8'h00, 8'h00, "d00_00");

        // Starts during RUN and DONE must be dropped.
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'hFF;
        ndone = 0;
        cyc   = -1;
        diff_at_done = '0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (cyc < 0) begin
                    cyc = i;
                    diff_at_done = diff;
                end
                start = 1'b1;
            end else if (ready) begin
                start = 1'b0;
            end else begin
                start = (i == 2);
            end
        end
        start = 1'b0;
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_latency", 32'(cyc), 32'(W));
        check("ign_diff", 32'(diff_at_done), 32'h0F);
        check("ign_borrow", 32'(borrow_out), 32'd0);
        check("ign_ready", 32'(ready), 32'd1);

        // Reset in the middle of RUN.
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_ready", 32'(ready), 32'd1);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_diff", 32'(diff), 32'd0);
        check("mrst_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mrst_no_done", 32'(ndone), 32'd0);
        run_op(8'h20, 8'h10, "post_rst");

        // Back-to-back with start held high.
        check("b2b_ready_pre", 32'(ready), 32'd1);
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h0F;
        @(posedge clk); #1;
        a     = 8'h0F;
        b     = 8'h3C;
        first_ready = -1;
        ndone = 0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("b2b_diff1", 32'(diff), 32'(ref_diff(8'h3C, 8'h0F)));
            end
            if (ready) begin
                first_ready = i;
                break;
            end
        end
        check("b2b_done1", 32'(ndone), 32'd1);
        @(posedge clk); #1;
        check("b2b_accepted", 32'(ready), 32'd0);
        check("b2b_spacing", 32'(first_ready + 1), 32'(W + 2));
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (W / 2) @(posedge clk);
        #1;
        check("b2b_hold", 32'(diff), 32'(ref_diff(8'h3C, 8'h0F)));
        wait_done(cyc);
        check("b2b_latency2", 32'(cyc + W / 2), 32'(W));
        check("b2b_diff2", 32'(diff), 32'(ref_diff(8'h0F, 8'h3C)));
        check("b2b_borrow2", 32'(borrow_out), 32'(ref_borrow(8'h0F, 8'h3C)));
        @(posedge clk); #1;

        // Random operands against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing a - b, LSB-first, one bit per clock. It is the subtract-direction counterpart of the team's adder blocks: the ripple uses a full subtractor cell built from two half subtractors, and a borrow flip-flop replaces the carry. It sits beside the adder as an area-cheap arithmetic unit, started through a start/ready handshake with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
ready  output  1  high in IDLE only
diff  output  WIDTH  a - b mod 2^WIDTH; valid from done until the next accepted start
borrow_out  output  1  1 when a < b (unsigned); valid with diff
done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset (async, active-high): state=IDLE, ready=1, done=0, diff=0, borrow_out=0, shift regs/counter/borrow FF=0.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> DONE after WIDTH bit cycles.
  - DONE -> IDLE unconditionally.
- Edge E0 (start=1 in IDLE):
  - Load a_sr<=a, b_sr<=b, bor<=0, cnt<=0.
  - State<=RUN, ready<=0.
- RUN, edges E1..E_WIDTH, one bit per edge:
  - d = a_sr[0]^b_sr[0]^bor.
  - bor <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&bor).
  - d shifts into the result register from the MSB side.
  - a_sr and b_sr shift right.
  - cnt increments.
- Edge E_WIDTH (cnt==WIDTH-1):
  - diff<=final result register, borrow_out<=final borrow.
  - State<=DONE, done<=1.
- Latency: done is high in the cycle after E_WIDTH, i.e. exactly WIDTH cycles after the start sample.
- Next edge: state<=IDLE, done<=0, ready<=1.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- start while ready=0 (RUN or DONE): ignored; not queued.
- a, b may change freely after E0; the captured values are used.
- diff and borrow_out hold their last result through IDLE. They are overwritten only at the E_WIDTH of the next operation; they are not cleared on start.
- Reset mid-RUN: immediately returns to reset values; no done pulse; partial result discarded.
- cnt width: $clog2(WIDTH); no wrap beyond WIDTH-1.
- Arithmetic: purely unsigned, modulo 2^WIDTH; borrow_out equals the borrow out of the MSB.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function.
- Sub-module full_subtractor (a, b, bin -> d, bout), built from two half_subtractor instances (d=a^b, bout=~a&b) with bout = bout1|bout2.
- FSM, shift registers and counter stay in the top.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start 1 cycle -> done 8 cycles after sample; diff=0x02, borrow_out=0; ready returns 1 the cycle after done.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
- a=0x80, b=0xFF -> diff=0x81, borrow_out=1. a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0. a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
- Start accepted with a=0x10, b=0x01; re-assert start with a=0x00, b=0xFF at cycle 3 and during DONE -> ignored; single done pulse with diff=0x0F.
- rst asserted at cycle 4 of RUN -> outputs immediately at reset values, no done pulse. After release, a=0x20, b=0x10 -> diff=0x10, borrow_out=0.
- Two back-to-back ops, start held high continuously -> second accepted exactly WIDTH+2 cycles after the first; previous diff holds until the second result lands.
